// File: rtl/poly_sequencer.sv
// poly_sequencer
//   Self-sequencing controller for the shared 8-bit polynomial datapath.
//   Accepts one operand set (A, B, C, x) over a valid/ready handshake, loads
//   the datapath registers a/b/c/x one per cycle, then issues the Horner
//   micro-sequence
//     C1: a <- a*x   C2: a <- a+b   C3: a <- a*x   C4: r <- a+c
//   so that r = A*x^2 + B*x + C (mod 256). The datapath result is captured in
//   WB and offered on a second valid/ready handshake.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   in_valid / in_ready         operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_c, in_x      operands, sampled on the accepting edge
//   out_valid / out_ready       result handshake
//   out_data                    result, stable while out_valid
//   busy                        load or compute in progress (LD_A..WB)
//   dp_data_in                  datapath data_in
//   dp_ld_a/b/c/x/r             datapath register load enables
//   dp_ld_alu_out               a/b/c/x load from ALU instead of data_in
//   dp_alu_select_a/b           ALU operand selects: 0=a, 1=b, 2=c, 3=x
//   dp_alu_op                   0=add, 1=multiply
//   dp_result                   datapath result register
module poly_sequencer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   input  logic [DATA_W-1:0] in_x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic [DATA_W-1:0] dp_data_in,
   output logic              dp_ld_a,
   output logic              dp_ld_b,
   output logic              dp_ld_c,
   output logic              dp_ld_x,
   output logic              dp_ld_r,
   output logic              dp_ld_alu_out,
   output logic [1:0]        dp_alu_select_a,
   output logic [1:0]        dp_alu_select_b,
   output logic              dp_alu_op,
   input  logic [DATA_W-1:0] dp_result
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LD_A = 4'd1,
      S_LD_B = 4'd2,
      S_LD_C = 4'd3,
      S_LD_X = 4'd4,
      S_C1   = 4'd5,
      S_C2   = 4'd6,
      S_C3   = 4'd7,
      S_C4   = 4'd8,
      S_WB   = 4'd9,
      S_DONE = 4'd10
   } state_t;

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_C = 2'd2;
   localparam logic [1:0] SEL_X = 2'd3;
   localparam logic       OP_ADD = 1'b0;
   localparam logic       OP_MUL = 1'b1;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d;
   logic [DATA_W-1:0]   res_q, res_d;

   logic [DATA_W-1:0]   data_in_q, data_in_d;
   logic                ld_a_q, ld_a_d, ld_b_q, ld_b_d;
   logic                ld_c_q, ld_c_d, ld_x_q, ld_x_d;
   logic                ld_r_q, ld_r_d, ld_alu_q, ld_alu_d;
   logic [1:0]          sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic                op_q, op_d;
   logic                busy_q, busy_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;

   // Next state, operand capture and result capture.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      x_d     = x_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_LD_A;
               a_d     = in_a;
               b_d     = in_b;
               c_d     = in_c;
               x_d     = in_x;
            end
         end
         S_LD_A: state_d = S_LD_B;
         S_LD_B: state_d = S_LD_C;
         S_LD_C: state_d = S_LD_X;
         S_LD_X: state_d = S_C1;
         S_C1:   state_d = S_C2;
         S_C2:   state_d = S_C3;
         S_C3:   state_d = S_C4;
         S_C4:   state_d = S_WB;
         S_WB: begin
            state_d = S_DONE;
            res_d   = dp_result;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the NEXT state and registered, so each output
   // flop holds the value belonging to the state the FSM is currently in.
   // LD_A uses a_d so the operand is presented in the cycle right after the
   // accepting edge.
   always_comb begin
      data_in_d   = '0;
      ld_a_d      = 1'b0;
      ld_b_d      = 1'b0;
      ld_c_d      = 1'b0;
      ld_x_d      = 1'b0;
      ld_r_d      = 1'b0;
      ld_alu_d    = 1'b0;
      sel_a_d     = SEL_A;
      sel_b_d     = SEL_A;
      op_d        = OP_ADD;
      busy_d      = 1'b0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      case (state_d)
         S_IDLE: in_ready_d = 1'b1;
         S_LD_A: begin
            data_in_d = a_d;
            ld_a_d    = 1'b1;
            busy_d    = 1'b1;
         end
         S_LD_B: begin
            data_in_d = b_d;
            ld_b_d    = 1'b1;
            busy_d    = 1'b1;
         end
         S_LD_C: begin
            data_in_d = c_d;
            ld_c_d    = 1'b1;
            busy_d    = 1'b1;
         end
         S_LD_X: begin
            data_in_d = x_d;
            ld_x_d    = 1'b1;
            busy_d    = 1'b1;
         end
         S_C1, S_C3: begin
            sel_a_d  = SEL_A;
            sel_b_d  = SEL_X;
            op_d     = OP_MUL;
            ld_a_d   = 1'b1;
            ld_alu_d = 1'b1;
            busy_d   = 1'b1;
         end
         S_C2: begin
            sel_a_d  = SEL_A;
            sel_b_d  = SEL_B;
            op_d     = OP_ADD;
            ld_a_d   = 1'b1;
            ld_alu_d = 1'b1;
            busy_d   = 1'b1;
         end
         S_C4: begin
            sel_a_d = SEL_A;
            sel_b_d = SEL_C;
            op_d    = OP_ADD;
            ld_r_d  = 1'b1;
            busy_d  = 1'b1;
         end
         S_WB:   busy_d      = 1'b1;
         S_DONE: out_valid_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         x_q         <= '0;
         res_q       <= '0;
         data_in_q   <= '0;
         ld_a_q      <= 1'b0;
         ld_b_q      <= 1'b0;
         ld_c_q      <= 1'b0;
         ld_x_q      <= 1'b0;
         ld_r_q      <= 1'b0;
         ld_alu_q    <= 1'b0;
         sel_a_q     <= '0;
         sel_b_q     <= '0;
         op_q        <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         x_q         <= x_d;
         res_q       <= res_d;
         data_in_q   <= data_in_d;
         ld_a_q      <= ld_a_d;
         ld_b_q      <= ld_b_d;
         ld_c_q      <= ld_c_d;
         ld_x_q      <= ld_x_d;
         ld_r_q      <= ld_r_d;
         ld_alu_q    <= ld_alu_d;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         op_q        <= op_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = out_valid_q;
   assign out_data        = res_q;
   assign busy            = busy_q;
   assign dp_data_in      = data_in_q;
   assign dp_ld_a         = ld_a_q;
   assign dp_ld_b         = ld_b_q;
   assign dp_ld_c         = ld_c_q;
   assign dp_ld_x         = ld_x_q;
   assign dp_ld_r         = ld_r_q;
   assign dp_ld_alu_out   = ld_alu_q;
   assign dp_alu_select_a = sel_a_q;
   assign dp_alu_select_b = sel_b_q;
   assign dp_alu_op       = op_q;

endmodule
